// File: rtl/uart_rx_engine.sv
// ---------------------------------------------------------------------------
// uart_rx_engine
//
// UART receive engine placed downstream of the auto-baud detector. It takes
// the measured bit period (BRG, in CLK cycles) and the shared UXRX line,
// deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) and
// presents each byte in a one-entry holding register with a ready flag.
// While ABAUD is high the engine is held in IDLE so the detector and the
// receiver never interpret the line at the same time.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : 8E1 frame, PAR state present, PERR reports even-parity errors
//   undefined : 8N1 frame, no PAR state, PERR constantly 0
//
// Ports:
//   CLK     in  system clock, rising edge
//   RST_N   in  asynchronous active-low reset
//   UXRX    in  serial line, asynchronous, idle high
//   ABAUD   in  auto-baud measurement active, forces IDLE
//   BRG     in  bit period in CLK cycles, latched at start-bit detection
//   RD      in  one-cycle read strobe, consumes the held byte
//   RXDATA  out received byte
//   UXRXIF  out byte available
//   FERR    out framing error of held byte
//   PERR    out parity error of held byte (0 in the 8N1 build)
//   OERR    out sticky overrun flag, cleared by RD
//   BUSY    out high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_rx_engine #(
  parameter int DATA_W  = 8,
  parameter int BRG_MIN = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              UXRX,
  input  logic              ABAUD,
  input  logic [7:0]        BRG,
  input  logic              RD,
  output logic [DATA_W-1:0] RXDATA,
  output logic              UXRXIF,
  output logic              FERR,
  output logic              PERR,
  output logic              OERR,
  output logic              BUSY
);

  localparam logic [7:0] BRG_MIN_C = 8'(BRG_MIN);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_err(input logic [DATA_W-1:0] data,
                                           input logic              par_bit);
    return (^data) ^ par_bit;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // Synchroniser and edge-detect history
  logic              sync1_q, sync2_q, prev_q;
  // Frame engine
  state_t            state_q, state_d;
  logic [7:0]        per_q, per_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  // Holding register
  logic [DATA_W-1:0] rxdata_q, rxdata_d;
  logic              uxrxif_q, uxrxif_d;
  logic              ferr_q, ferr_d;
  logic              oerr_q, oerr_d;
  logic              busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              perr_hold_q, perr_hold_d;
`endif

  logic fall_s;
  logic tick_s;
  logic complete_s;

  assign fall_s = prev_q & ~sync2_q;
  assign tick_s = (cnt_q == 8'd1);

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= UXRX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM next-state, baud counter, bit counter and shift register.
  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    complete_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif

    // Counter free-runs while a frame is in progress; reloads after each tick.
    if (state_q != S_IDLE) begin
      if (tick_s) begin
        cnt_d = per_q;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (ABAUD) begin
      // Auto-baud owns the line: drop any partial frame, touch no flags.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall_s && (BRG >= BRG_MIN_C)) begin
            state_d  = S_START;
            per_d    = BRG;
            cnt_d    = BRG >> 1;
            bitcnt_d = 4'd0;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_START: begin
          if (tick_s) begin
            // Line back high at mid-start means a glitch, not a frame.
            if (!sync2_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_START;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            shift_d = {sync2_q, shift_q[DATA_W-1:1]};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_d  = S_PAR;
`else
              state_d  = S_STOP;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end else begin
            state_d = S_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (tick_s) begin
            perr_d  = even_parity_err(shift_q, sync2_q);
            state_d = S_STOP;
          end else begin
            state_d = S_PAR;
          end
        end
`endif
        S_STOP: begin
          if (tick_s) begin
            complete_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d    = S_STOP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Holding register, ready flag and overrun handling.
  always_comb begin
    rxdata_d = rxdata_q;
    uxrxif_d = uxrxif_q;
    ferr_d   = ferr_q;
    oerr_d   = oerr_q;
`ifdef UART_RX_PARITY_EN
    perr_hold_d = perr_hold_q;
`endif

    if (complete_s) begin
      rxdata_d = shift_q;
      ferr_d   = ~sync2_q;
      uxrxif_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_hold_d = perr_q;
`endif
      // Unread byte overwritten -> overrun; a same-cycle read consumes it.
      if (uxrxif_q && !RD) begin
        oerr_d = 1'b1;
      end else if (uxrxif_q && RD) begin
        oerr_d = 1'b0;
      end else begin
        oerr_d = oerr_q;
      end
    end else if (RD && uxrxif_q) begin
      uxrxif_d = 1'b0;
      oerr_d   = 1'b0;
    end else begin
      uxrxif_d = uxrxif_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      per_q       <= 8'd0;
      cnt_q       <= 8'd0;
      bitcnt_q    <= 4'd0;
      shift_q     <= '0;
      rxdata_q    <= '0;
      uxrxif_q    <= 1'b0;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_hold_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rxdata_q    <= rxdata_d;
      uxrxif_q    <= uxrxif_d;
      ferr_q      <= ferr_d;
      oerr_q      <= oerr_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
      perr_hold_q <= perr_hold_d;
`endif
    end
  end

  assign RXDATA = rxdata_q;
  assign UXRXIF = uxrxif_q;
  assign FERR   = ferr_q;
  assign OERR   = oerr_q;
  assign BUSY   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign PERR   = perr_hold_q;
`else
  assign PERR   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_engine
//
// Self-checking bench for uart_rx_engine. Inputs are driven on the falling
// clock edge and outputs sampled there. A frame-level reference model keeps
// the expected holding register, flags and completion time; frames are
// built bit by bit from the byte, stop and parity values.
// Honours UART_RX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_rx_engine;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       UXRX  = 1'b1;
  logic       ABAUD = 1'b0;
  logic [7:0] BRG   = 8'd16;
  logic       RD    = 1'b0;
  logic [7:0] RXDATA;
  logic       UXRXIF, FERR, PERR, OERR, BUSY;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model of the holding register
  logic [7:0] exp_data = 8'h00;
  logic       exp_if   = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;
  logic       exp_oerr = 1'b0;

  uart_rx_engine dut (
    .CLK(CLK), .RST_N(RST_N), .UXRX(UXRX), .ABAUD(ABAUD), .BRG(BRG), .RD(RD),
    .RXDATA(RXDATA), .UXRXIF(UXRXIF), .FERR(FERR), .PERR(PERR), .OERR(OERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_rxdata"}, 32'(RXDATA), 32'(exp_data));
    check({tag, "_uxrxif"}, 32'(UXRXIF), 32'(exp_if));
    check({tag, "_ferr"},   32'(FERR),   32'(exp_ferr));
    check({tag, "_perr"},   32'(PERR),   32'(exp_perr));
    check({tag, "_oerr"},   32'(OERR),   32'(exp_oerr));
  endtask

  // Line level for bit slot idx of a frame: start, data LSB first, [parity], stop, idle.
  function automatic logic frame_bit(input logic [7:0] d, input logic par,
                                     input logic stp, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_RX_PARITY_EN
    if (idx == 9)  return par;
    if (idx == 10) return stp;
`else
    if (idx == 9)  return stp;
`endif
    return 1'b1;
  endfunction

  // Cycles from driving the start edge to the first sample showing the byte:
  // 3 cycles of synchroniser/edge detect, half a period, then one period per
  // bit up to and including the stop bit.
  function automatic int exp_fall(input int per);
    return 3 + per / 2 + (NBITS - 1) * per;
  endfunction

  task automatic model_complete(input logic [7:0] d, input logic stp,
                                input logic par, input logic rd_in);
    exp_data = d;
    exp_ferr = ~stp;
`ifdef UART_RX_PARITY_EN
    exp_perr = (^d) ^ par;
`else
    exp_perr = 1'b0;
`endif
    if (exp_if && !rd_in) exp_oerr = 1'b1;
    else if (exp_if && rd_in) exp_oerr = 1'b0;
    exp_if = 1'b1;
  endtask

  task automatic do_read();
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    if (exp_if) begin
      exp_if   = 1'b0;
      exp_oerr = 1'b0;
    end
  endtask

  // Drive one frame plus tail; record when BUSY falls and any later re-rise.
  task automatic send_frame(input logic [7:0] d, input int per, input logic stp,
                            input logic par, input int rd_at, input int abaud_at,
                            input logic tail_val, input int tail_len,
                            output int fall_at, output int rises);
    logic prev_busy;
    int   total;
    BRG       = 8'(per);
    prev_busy = BUSY;
    fall_at   = -1;
    rises     = 0;
    total     = NBITS * per + tail_len;
    for (int c = 0; c < total; c++) begin
      if (c < NBITS * per) UXRX = frame_bit(d, par, stp, c / per);
      else                 UXRX = tail_val;
      if (abaud_at >= 0 && c > abaud_at) UXRX = 1'b1;
      RD    = (c == rd_at);
      ABAUD = (c == abaud_at);
      // BRG must be latched at the start edge; disturb it mid-frame.
      if (c == per) BRG = 8'($urandom_range(0, 255));
      @(negedge CLK);
      if (prev_busy && !BUSY && fall_at < 0) fall_at = c + 1;
      if (!prev_busy && BUSY && fall_at >= 0) rises++;
      prev_busy = BUSY;
    end
    RD    = 1'b0;
    ABAUD = 1'b0;
    BRG   = 8'(per);
  endtask

  initial begin
    int fall, rises, per, bcnt, rd_at;
    logic [7:0] d;
    logic stp, par, rd_flag;

    // ---------------- reset ----------------
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check_hold("reset");
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    // ---------------- clean byte, BRG=16 ----------------
    send_frame(8'hA5, 16, 1'b1, 1'b0, -1, -1, 1'b1, 20, fall, rises);
    model_complete(8'hA5, 1'b1, 1'b0, 1'b0);
    check("clean_fall", 32'(fall), 32'(exp_fall(16)));
    check("clean_rises", 32'(rises), 32'd0);
    check_hold("clean");

    // ---------------- false start ----------------
    do_read();
    check("read_clear_if", 32'(UXRXIF), 32'd0);
    BRG  = 8'd16;
    bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      UXRX = (c < 4) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (BUSY) bcnt++;
    end
    check("false_busy_cycles", 32'(bcnt), 32'd8);
    check_hold("false_start");

    // ---------------- framing error, line held low ----------------
    send_frame(8'h3C, 10, 1'b0, 1'b0, -1, -1, 1'b0, 30, fall, rises);
    model_complete(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_fall", 32'(fall), 32'(exp_fall(10)));
    check("ferr_no_retrigger", 32'(rises), 32'd0);
    check_hold("ferr");
    UXRX = 1'b1;
    repeat (5) @(negedge CLK);
    check("ferr_idle_busy", 32'(BUSY), 32'd0);
    do_read();
    send_frame(8'h5A, 10, 1'b1, 1'b0, -1, -1, 1'b1, 14, fall, rises);
    model_complete(8'h5A, 1'b1, 1'b0, 1'b0);
    check("after_ferr_fall", 32'(fall), 32'(exp_fall(10)));
    check_hold("after_ferr");

    // ---------------- overrun ----------------
    do_read();
    send_frame(8'h11, 8, 1'b1, 1'b0, -1, -1, 1'b1, 12, fall, rises);
    model_complete(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b1, 1'b0, -1, -1, 1'b1, 12, fall, rises);
    model_complete(8'h22, 1'b1, 1'b0, 1'b0);
    check_hold("overrun");
    do_read();
    check_hold("overrun_read");
    send_frame(8'h11, 8, 1'b1, 1'b0, -1, -1, 1'b1, 12, fall, rises);
    model_complete(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b1, 1'b0, exp_fall(8) - 1, -1, 1'b1, 12, fall, rises);
    model_complete(8'h22, 1'b1, 1'b0, 1'b1);
    check_hold("overrun_rd_same_cycle");

    // ---------------- parity frames (PERR 0 in 8N1 build) ----------------
    send_frame(8'h07, 12, 1'b1, 1'b1, -1, -1, 1'b1, 16, fall, rises);
    model_complete(8'h07, 1'b1, 1'b1, 1'b0);
    check("par1_fall", 32'(fall), 32'(exp_fall(12)));
    check_hold("par1");
    send_frame(8'h07, 12, 1'b1, 1'b0, -1, -1, 1'b1, 16, fall, rises);
    model_complete(8'h07, 1'b1, 1'b0, 1'b0);
    check_hold("par0");

    // ---------------- BRG below minimum ----------------
    send_frame(8'h00, 3, 1'b1, 1'b0, -1, -1, 1'b1, 8, fall, rises);
    check("brg_min_no_busy", 32'(fall), 32'hFFFF_FFFF);
    check_hold("brg_min");

    // ---------------- ABAUD abort during bit 3 ----------------
    send_frame(8'h96, 12, 1'b1, 1'b0, -1, 4 * 12 + 6, 1'b1, 16, fall, rises);
    check("abaud_fall", 32'(fall), 32'(4 * 12 + 7));
    check("abaud_rises", 32'(rises), 32'd0);
    check_hold("abaud");

    // ---------------- reset during bit 5 ----------------
    BRG = 8'd8;
    for (int c = 0; c < 6 * 8 + 4; c++) begin
      UXRX = frame_bit(8'h00, 1'b0, 1'b1, c / 8);
      @(negedge CLK);
    end
    check("prereset_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    exp_data = 8'h00; exp_if = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_oerr = 1'b0;
    check("midreset_busy", 32'(BUSY), 32'd0);
    check_hold("midreset");
    UXRX = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3 * 8) @(negedge CLK);
    check("postreset_busy", 32'(BUSY), 32'd0);
    check_hold("postreset");

    // ---------------- randomized frames ----------------
    for (int i = 0; i < 12; i++) begin
      per     = int'($urandom_range(4, 24));
      d       = 8'($urandom_range(0, 255));
      stp     = ($urandom_range(0, 4) != 0);
      par     = (^d) ^ ($urandom_range(0, 3) == 0);
      rd_flag = ($urandom_range(0, 3) == 0);
      rd_at   = rd_flag ? exp_fall(per) - 1 : -1;
      send_frame(d, per, stp, par, rd_at, -1, 1'b1, per + 4, fall, rises);
      model_complete(d, stp, par, rd_flag);
      check($sformatf("rand%0d_fall", i), 32'(fall), 32'(exp_fall(per)));
      check_hold($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        do_read();
        check_hold($sformatf("rand%0d_read", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
